// File: rtl/blk_mem_ram_pkg.sv
// Shared constants and word/address types for the simple dual-port block RAM.
package blk_mem_ram_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/blk_mem_ram_array.sv
// Raw storage: one write port, one registered read port, no reset, read-first.
module blk_mem_ram_array
  import blk_mem_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // Power-up contents are all-zero via the declaration initialiser.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/blk_mem_ram_ip.sv
// Simple dual-port RAM wrapper: reset masking of read data plus an optional
// second output stage enabled by BLK_MEM_OUTPUT_REG_EN.
module blk_mem_ram_ip
  import blk_mem_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb
);

  logic              we_gated;
  logic [DATA_W-1:0] ram_q;
  logic              rd_valid_reg;
  logic [DATA_W-1:0] stage1;

  assign we_gated = wea & ~rst;

  blk_mem_ram_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (clka),
    .we   (we_gated),
    .waddr(addra),
    .wdata(dina),
    .raddr(addrb),
    .rdata(ram_q)
  );

  // The array's read register has no reset, so its output is masked until
  // the first edge after reset release has performed a fresh read.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= 1'b1;
    end
  end

  assign stage1 = rd_valid_reg ? ram_q : '0;

`ifdef BLK_MEM_OUTPUT_REG_EN
  logic [DATA_W-1:0] dout_reg;

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      dout_reg <= '0;
    end else begin
      dout_reg <= stage1;
    end
  end

  assign doutb = dout_reg;
`else
  assign doutb = stage1;
`endif

endmodule

// File: tb/tb_blk_mem_ram_ip.sv
// Scoreboard bench for blk_mem_ram_ip; honours BLK_MEM_OUTPUT_REG_EN latency.
module tb_blk_mem_ram_ip;

`ifdef BLK_MEM_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    bit         chk;
    logic [7:0] val;
    logic [7:0] addr;
  } exp_t;

  logic       clka = 1'b0;
  logic       rst  = 1'b1;
  logic       wea  = 1'b0;
  logic [7:0] addra = '0;
  logic [7:0] dina  = '0;
  logic [7:0] addrb = 8'd255;
  logic [7:0] doutb;

  logic [7:0] model [256];
  exp_t       exp_q [$];
  int         checks = 0;
  int         errors = 0;

  blk_mem_ram_ip dut (
    .clka (clka),
    .rst  (rst),
    .wea  (wea),
    .addra(addra),
    .dina (dina),
    .addrb(addrb),
    .doutb(doutb)
  );

  always #5 clka = ~clka;

  // One clock: drive inputs, record the read-first expectation, apply the
  // model write, then compare whatever has reached the output.
  task automatic cycle(input bit w, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] rb, input bit chk);
    exp_t e;
    wea = w; addra = a; dina = d; addrb = rb;
    e.chk = chk; e.val = model[rb]; e.addr = rb;
    exp_q.push_back(e);
    if (w && !rst) model[a] = d;
    @(posedge clka);
    #1;
    if (exp_q.size() >= LAT) begin
      e = exp_q.pop_front();
      if (e.chk) begin
        checks++;
        if (doutb !== e.val) begin
          errors++;
          $display("FAIL read addr=%0d doutb=%02h expected=%02h", e.addr, doutb, e.val);
        end else begin
          $display("read addr=%0d doutb=%02h ok", e.addr, doutb);
        end
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < LAT - 1; i++) cycle(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (doutb !== 8'h00) begin
      errors++;
      $display("FAIL reset_immediate doutb=%02h expected=00", doutb);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clka); #1;
      checks++;
      if (doutb !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold doutb=%02h expected=00", doutb);
      end else $display("reset cycle %0d doutb=00 ok", i);
    end
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 8'(8'hFF - i), 8'd200, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'd0, 8'd0, 8'(i), 1'b1);
    drain();
  endtask

  task automatic test_write_disable();
    cycle(1'b0, 8'd3, 8'hAA, 8'd100, 1'b0);
    cycle(1'b0, 8'd3, 8'hAA, 8'd3, 1'b1);
    drain();
  endtask

  task automatic test_collision();
    cycle(1'b1, 8'd5, 8'h11, 8'd5, 1'b1);
    cycle(1'b0, 8'd0, 8'd0, 8'd5, 1'b1);
    drain();
  endtask

  task automatic test_boundary();
    cycle(1'b1, 8'd255, 8'h5A, 8'd1, 1'b1);
    cycle(1'b1, 8'd0, 8'h00, 8'd255, 1'b1);
    cycle(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    cycle(1'b0, 8'd0, 8'd0, 8'd255, 1'b1);
    drain();
  endtask

  task automatic test_reset_mid_read();
    for (int i = 0; i < LAT; i++) cycle(1'b0, 8'd0, 8'd0, 8'd2, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (doutb !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_read doutb=%02h expected=00", doutb);
    end else $display("reset mid-read doutb=00 ok");
    // A write attempted under reset must not land.
    wea = 1'b1; addra = 8'd2; dina = 8'h77;
    @(posedge clka); #1;
    checks++;
    if (doutb !== 8'h00) begin
      errors++;
      $display("FAIL reset_write_blocked_out doutb=%02h expected=00", doutb);
    end
    wea = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'd0, 8'd0, 8'd2, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 15)), 1'b1);
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    test_reset();
    test_fill();
    test_write_disable();
    test_collision();
    test_boundary();
    test_reset_mid_read();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/blk_mem_ram_ip.md
BLK_MEM_RAM_IP -- requirements
Module: blk_mem_ram_ip

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data word width in bits.
REQ-002 Parameter ADDR_W, default 8, SHALL set the address width in bits.
REQ-003 Parameter DEPTH, default 2**ADDR_W (256), SHALL set the number of words.
REQ-004 Port clka, input, 1 bit, SHALL be the single clock for both ports; all logic is rising-edge triggered.
REQ-005 Port rst, input, 1 bit, SHALL be the reset; it is asynchronous and active-high.
REQ-006 Port wea, input, 1 bit, SHALL be the port-A write enable.
REQ-007 Port addra, input, ADDR_W bits, SHALL be the port-A write address.
REQ-008 Port dina, input, DATA_W bits, SHALL be the port-A write data.
REQ-009 Port addrb, input, ADDR_W bits, SHALL be the port-B read address.
REQ-010 Port doutb, output, DATA_W bits, SHALL be the port-B registered read data.

Function
REQ-011 The block SHALL be a simple dual-port RAM of DEPTH x DATA_W: port A is write-only and port B is read-only.
REQ-012 When wea=1 at a clka rising edge and rst=0, mem[addra] SHALL take dina at that edge.
REQ-013 When wea=0, memory contents SHALL be unchanged regardless of addra and dina.
REQ-014 addrb SHALL be sampled every rising edge with no read enable; doutb SHALL show mem[addrb] after that same edge (1-cycle latency).
REQ-015 Read-during-write to the same address in the same cycle SHALL be read-first: doutb shows the old word, and the new word is visible one cycle later.
REQ-016 Reads and writes to different addresses in the same cycle SHALL be fully independent.
REQ-017 Every address 0..DEPTH-1 SHALL be distinct storage with no aliasing; addresses SHALL NOT be bounds-checked or wrapped, since the full ADDR_W range is valid.
REQ-018 Memory contents SHALL be initialised to all-zero at configuration/simulation start.
REQ-019 doutb SHALL only change on a clka rising edge or on rst assertion.

Reset
REQ-020 While rst=1, doutb and any output pipeline register SHALL be 0, asynchronously and immediately on assertion.
REQ-021 While rst=1, writes SHALL be blocked.
REQ-022 Reset SHALL NOT clear memory contents; data written before reset SHALL read back unchanged after reset release.
REQ-023 After rst deasserts, the first rising edge SHALL perform a normal read of addrb.

Configuration
REQ-024 Macro BLK_MEM_OUTPUT_REG_EN SHALL control an extra output register stage.
REQ-025 When BLK_MEM_OUTPUT_REG_EN is defined, an extra register stage SHALL follow the read register, giving a read latency of 2 cycles; that stage SHALL also reset to 0 and preserve read-first ordering.
REQ-026 When BLK_MEM_OUTPUT_REG_EN is undefined, read latency SHALL be 1 cycle with no added register.

Structure
REQ-027 Package blk_mem_ram_pkg SHALL hold the default DATA_W, ADDR_W and DEPTH constants and the word/address typedefs.
REQ-028 Storage SHALL be isolated in sub-module blk_mem_ram_array (write port plus synchronous read port, no reset), inferable as block RAM.
REQ-029 Reset and the optional output stage SHALL live in blk_mem_ram_ip.

Verification
REQ-030 Reset: assert rst with addrb=255 -> doutb=0x00 immediately and throughout reset.
REQ-031 Fill: wea=1, write addra=i, dina=0xFF-i for i=0..15, then set wea=0 and read addrb=0..15 -> doutb=0xFF,0xFE,...,0xF0, each one cycle after its address (two cycles with BLK_MEM_OUTPUT_REG_EN).
REQ-032 Write disable: wea=0, addra=3, dina=0xAA -> read of address 3 still returns 0xFC.
REQ-033 Collision: write 0x11 to address 5 while addrb=5 -> doutb=0xFA on that edge and 0x11 on the next edge.
REQ-034 Boundary: write 0x5A to address 255 and 0x00 to address 0 -> read of 255 returns 0x5A and read of 0 returns 0x00.
REQ-035 Reset mid-read: assert rst while reading address 2 -> doutb=0 at once; release rst -> read of address 2 returns 0xFD.
